// File: rtl/banked_regfile_if.sv
// Decode/ALU-facing bus of the banked register file: control strobes in, architectural state out.
interface banked_regfile_if #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned NREGS  = 4,
  parameter int unsigned NBANKS = 2,
  parameter int unsigned RSW    = $clog2(NREGS),
  parameter int unsigned BW     = (NBANKS > 2) ? $clog2(NBANKS) : 1
);
  logic [RSW-1:0]     rs;
  logic               rd;
  logic               wr;
  logic               wa;
  logic               isp;
  logic               ljr;
  logic [2*WIDTH-1:0] ra;
  logic [WIDTH-1:0]   aluout;
  logic               irq_take;
  logic [2*WIDTH-1:0] irq_ra;
  logic               irq_ret;
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   sp;
  logic [WIDTH-1:0]   sel;
  logic [2*WIDTH-1:0] ret_addr;
  logic [BW-1:0]      bank;
  logic               nest_full;
  logic               nest_err;

  modport master (
    output rs, rd, wr, wa, isp, ljr, ra, aluout, irq_take, irq_ra, irq_ret,
    input  acc, sp, sel, ret_addr, bank, nest_full, nest_err
  );

  modport slave (
    input  rs, rd, wr, wa, isp, ljr, ra, aluout, irq_take, irq_ra, irq_ret,
    output acc, sp, sel, ret_addr, bank, nest_full, nest_err
  );
endinterface

// File: rtl/banked_regfile.sv
// Register file with unbanked acc/sp and NBANKS banked data contexts, switched by a
// saturating bank pointer on interrupt entry/return with background return-address capture.
module banked_regfile #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned NREGS  = 4,
  parameter int unsigned NBANKS = 2,
  parameter int unsigned RSW    = $clog2(NREGS),
  parameter int unsigned BW     = (NBANKS > 2) ? $clog2(NBANKS) : 1
) (
  input logic             clk,
  input logic             nclr,
  banked_regfile_if.slave bus
);
  localparam logic [BW-1:0] LastBank = BW'(NBANKS - 1);

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sp_q, sp_d;
  logic [BW-1:0]    bank_q, bank_d;
  logic             nest_err_q, nest_err_d;
  // Slots 0/1 of each bank are never written; acc/sp live outside the banks.
  logic [WIDTH-1:0] regs_q [NBANKS][NREGS];
  logic [WIDTH-1:0] regs_d [NBANKS][NREGS];

  logic [31:0]      rs_ext;
  logic             rs_banked;
  logic             at_top, at_bottom;
  logic             take_only, ret_only, take_ret;
  logic             cap_en;
  logic [BW-1:0]    cap_bank;
  logic [WIDTH-1:0] sel_val;

  assign rs_ext    = 32'(bus.rs);
  assign rs_banked = (rs_ext >= 32'd2) && (rs_ext < NREGS);
  assign at_top    = (bank_q == LastBank);
  assign at_bottom = (bank_q == '0);
  assign take_only = bus.irq_take & ~bus.irq_ret;
  assign ret_only  = bus.irq_ret & ~bus.irq_take;
  assign take_ret  = bus.irq_take & bus.irq_ret;
  assign cap_en    = take_ret | (take_only & ~at_top);
  assign cap_bank  = take_ret ? bank_q : bank_q + BW'(1);

  always_comb begin
    sel_val = '0;
    if (rs_ext == 32'd0) begin
      sel_val = acc_q;
    end else if (rs_ext == 32'd1) begin
      sel_val = sp_q;
    end else if (rs_banked) begin
      sel_val = regs_q[bank_q][bus.rs];
    end
  end

  always_comb begin
    acc_d = acc_q;
    if (bus.rd) begin
      // rd owns acc this cycle; rs=0 is a no-op that also blocks wa.
      if (rs_ext == 32'd1) begin
        acc_d = sp_q;
      end else if (rs_banked) begin
        acc_d = regs_q[bank_q][bus.rs];
      end
    end else if (bus.wa) begin
      acc_d = bus.aluout;
    end
  end

  always_comb begin
    sp_d = sp_q;
    if (bus.wr && (rs_ext == 32'd1)) begin
      sp_d = acc_q;
    end else if (bus.isp) begin
      sp_d = bus.aluout;
    end
  end

  always_comb begin
    bank_d     = bank_q;
    nest_err_d = nest_err_q;
    if (take_only) begin
      if (at_top) nest_err_d = 1'b1;
      else        bank_d     = bank_q + BW'(1);
    end
    if (ret_only) begin
      if (at_bottom) nest_err_d = 1'b1;
      else           bank_d     = bank_q - BW'(1);
    end
  end

  // Architectural writes hit the pre-change bank; the irq capture lands last so it wins.
  always_comb begin
    regs_d = regs_q;
    if (bus.ljr) begin
      regs_d[bank_q][2] = bus.ra[WIDTH-1:0];
      regs_d[bank_q][3] = bus.ra[2*WIDTH-1:WIDTH];
    end
    if (bus.wr && rs_banked) begin
      regs_d[bank_q][bus.rs] = acc_q;
    end
    if (cap_en) begin
      regs_d[cap_bank][2] = bus.irq_ra[WIDTH-1:0];
      regs_d[cap_bank][3] = bus.irq_ra[2*WIDTH-1:WIDTH];
    end
  end

  always_ff @(posedge clk or negedge nclr) begin
    if (!nclr) begin
      acc_q      <= '0;
      sp_q       <= '0;
      bank_q     <= '0;
      nest_err_q <= 1'b0;
      for (int b = 0; b < NBANKS; b++) begin
        for (int r = 0; r < NREGS; r++) begin
          regs_q[b][r] <= '0;
        end
      end
    end else begin
      acc_q      <= acc_d;
      sp_q       <= sp_d;
      bank_q     <= bank_d;
      nest_err_q <= nest_err_d;
      regs_q     <= regs_d;
    end
  end

  assign bus.acc       = acc_q;
  assign bus.sp        = sp_q;
  assign bus.sel       = sel_val;
  assign bus.ret_addr  = {regs_q[bank_q][3], regs_q[bank_q][2]};
  assign bus.bank      = bank_q;
  assign bus.nest_full = at_top;
  assign bus.nest_err  = nest_err_q;
endmodule
